// File: rtl/mono_hit_tx.sv
// MONOPIX chip-side readout emulator: hit FIFO, TOKEN/FREEZE handling, 30-bit serial word out.
// Define MONO_HIT_TX_GRAY_EN to gray-encode the LE/TE timestamps in the word.
module mono_hit_tx #(
    parameter int ADDR_W = 4,
    parameter int LOST_W = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              HIT_VALID,
    input  logic [5:0]        HIT_COL,
    input  logic [7:0]        HIT_ROW,
    input  logic [7:0]        HIT_LE,
    input  logic [7:0]        HIT_TE,
    output logic              HIT_READY,
    input  logic              READ,
    input  logic              FREEZE,
    input  logic              MATRIX_nRST,
    output logic              TOKEN,
    output logic              DATA,
    output logic              BUSY,
    output logic [LOST_W-1:0] LOST_CNT
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_W:0]     fcnt_q, fcnt_d;
    logic [ADDR_W:0]     occ;
    logic [29:0]         mem_q [DEPTH];
    logic [29:0]         sr_q, sr_d;
    logic [4:0]          bitcnt_q, bitcnt_d;
    logic                busy_q, busy_d;
    logic                token_q, token_d;
    logic                read_q, freeze_q;
    logic [LOST_W-1:0]   lost_q, lost_d;
    logic                full, empty, push, pop, rd_edge, frz_edge;
    logic [7:0]          le_c, te_c;
    logic [29:0]         word;

`ifdef MONO_HIT_TX_GRAY_EN
    assign le_c = HIT_LE ^ (HIT_LE >> 1);
    assign te_c = HIT_TE ^ (HIT_TE >> 1);
`else
    assign le_c = HIT_LE;
    assign te_c = HIT_TE;
`endif

    assign word  = {le_c, te_c, HIT_ROW, HIT_COL};
    assign occ   = wptr_q - rptr_q;
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                   (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

    assign rd_edge  = READ & ~read_q;
    assign frz_edge = FREEZE & ~freeze_q;
    assign push     = HIT_VALID & ~full & MATRIX_nRST;
    assign pop      = (state_q == IDLE) & rd_edge & token_q & ~empty & MATRIX_nRST;

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        fcnt_d   = fcnt_q;
        sr_d     = sr_q;
        bitcnt_d = bitcnt_q;
        busy_d   = busy_q;
        lost_d   = lost_q;

        if (pop) begin
            rptr_d   = rptr_q + 1'b1;
            sr_d     = mem_q[rptr_q[ADDR_W-1:0]];
            bitcnt_d = 5'd29;
            busy_d   = 1'b1;
            state_d  = SHIFT;
        end else if (state_q == SHIFT) begin
            sr_d     = sr_q << 1;
            bitcnt_d = bitcnt_q - 5'd1;
            if (bitcnt_q == 5'd0) begin
                bitcnt_d = 5'd0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        end

        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end

        if (HIT_VALID && full && MATRIX_nRST && !(&lost_q)) begin
            lost_d = lost_q + 1'b1;
        end

        // Frozen set is sized before this cycle's push; a same-cycle pop leaves it.
        if (frz_edge) begin
            fcnt_d = occ - {{ADDR_W{1'b0}}, pop};
        end else if (FREEZE && pop && fcnt_q != '0) begin
            fcnt_d = fcnt_q - 1'b1;
        end

        if (!MATRIX_nRST) begin
            wptr_d   = '0;
            rptr_d   = '0;
            fcnt_d   = '0;
            sr_d     = '0;
            bitcnt_d = '0;
            busy_d   = 1'b0;
            state_d  = IDLE;
        end

        token_d = FREEZE ? (fcnt_d != '0) : (wptr_d != rptr_d);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            fcnt_q   <= '0;
            sr_q     <= '0;
            bitcnt_q <= '0;
            busy_q   <= 1'b0;
            token_q  <= 1'b0;
            lost_q   <= '0;
            read_q   <= 1'b0;
            freeze_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            fcnt_q   <= fcnt_d;
            sr_q     <= sr_d;
            bitcnt_q <= bitcnt_d;
            busy_q   <= busy_d;
            token_q  <= token_d;
            lost_q   <= lost_d;
            read_q   <= READ;
            freeze_q <= FREEZE;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= word;
        end
    end

    assign HIT_READY = ~full;
    assign TOKEN     = token_q;
    assign DATA      = sr_q[29];
    assign BUSY      = busy_q;
    assign LOST_CNT  = lost_q;

endmodule
